// File: rtl/fifo_slave_pkg.sv
// rtl/fifo_slave_pkg.sv - register offsets and STATUS bit positions for fifo_slave
package fifo_slave_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_COUNT  = 4'h2;
  localparam logic [3:0] ADDR_CLEAR  = 4'h3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UDF   = 3;

endpackage

// File: rtl/fifo_core.sv
// rtl/fifo_core.sv - DEPTH x 32 storage with wrapping pointers and occupancy count
// Push-when-full and pop-when-empty are ignored here; the slave reports them.
module fifo_core #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [31:0]   wr_data_i,
  output logic [31:0]   rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_FULL);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  // Storage is never reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && !clear_i && do_push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (do_push) begin
      wptr_q  <= wptr_q + PTR_ONE;
      count_q <= count_q + CNT_ONE;
    end else if (do_pop) begin
      rptr_q  <= rptr_q + PTR_ONE;
      count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/fifo_slave.sv
// rtl/fifo_slave.sv - bus slave exposing a 32-bit FIFO through DATA/STATUS/COUNT/CLEAR
// Decodes one access per cycle, keeps sticky error flags and registers read data and irq.
module fifo_slave
  import fifo_slave_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  offset;
  logic        rd_acc, wr_acc;
  logic        push, pop, clear, st_wr;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty, fifo_full;
  logic [AW:0] fifo_count;
  logic [31:0] status_word;
  logic [31:0] dout_q, dout_d;
  logic        ovf_q, ovf_d, udf_q, udf_d, irq_q;

  assign offset = S_address[3:0];
  assign rd_acc = S_sel && !S_wr;
  assign wr_acc = S_sel && S_wr;
  assign push   = wr_acc && (offset == ADDR_DATA);
  assign pop    = rd_acc && (offset == ADDR_DATA);
  assign clear  = wr_acc && (offset == ADDR_CLEAR);
  assign st_wr  = wr_acc && (offset == ADDR_STATUS);

  fifo_core #(.DEPTH(DEPTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .clear_i   (clear),
    .wr_data_i (S_din),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  always_comb begin
    status_word         = '0;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_OVF]   = ovf_q;
    status_word[ST_UDF]   = udf_q;
  end

  always_comb begin
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    dout_d = dout_q;
    if (clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push && fifo_full) ovf_d = 1'b1;
    if (pop && fifo_empty) udf_d = 1'b1;
    if (st_wr && S_din[ST_OVF]) ovf_d = 1'b0;
    if (st_wr && S_din[ST_UDF]) udf_d = 1'b0;
    // S_dout only moves on reads to this slave; other cycles hold it.
    if (rd_acc) begin
      case (offset)
        ADDR_DATA:   dout_d = fifo_empty ? 32'd0 : fifo_rd_data;
        ADDR_STATUS: dout_d = status_word;
        ADDR_COUNT:  dout_d = 32'(fifo_count);
        default:     dout_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      irq_q  <= ovf_q | udf_q;
    end
  end

  assign S_dout = dout_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_fifo_slave.sv
// tb/tb_fifo_slave.sv - directed vector table plus hand sequences for fifo_slave
module tb_fifo_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        S_sel = 1'b0;
  logic        S_wr = 1'b0;
  logic [7:0]  S_address = 8'h0;
  logic [31:0] S_din = 32'h0;
  logic [31:0] S_dout;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fifo_slave #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .S_sel     (S_sel),
    .S_wr      (S_wr),
    .S_address (S_address),
    .S_din     (S_din),
    .S_dout    (S_dout),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic sel, input logic wr, input logic [7:0] addr,
                              input logic [31:0] din, input logic [31:0] exp_dout,
                              input logic exp_irq, input string name);
    vec_t v;
    v.sel = sel; v.wr = wr; v.addr = addr; v.din = din;
    v.exp_dout = exp_dout; v.exp_irq = exp_irq; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic sel, input logic wr, input logic [7:0] addr, input logic [31:0] din);
    S_sel = sel; S_wr = wr; S_address = addr; S_din = din;
    @(posedge clk);
    #1;
    S_sel = 1'b0; S_wr = 1'b0; S_address = 8'h0; S_din = 32'h0;
  endtask

  task automatic chk_dout(input string name, input logic [31:0] want);
    n_cmp++;
    if (S_dout !== want) begin
      n_bad++;
      $display("FAIL %s: S_dout got %h want %h", name, S_dout, want);
    end
  endtask

  task automatic chk_irq(input string name, input logic want);
    n_cmp++;
    if (irq !== want) begin
      n_bad++;
      $display("FAIL %s: irq got %b want %b", name, irq, want);
    end
  endtask

  initial begin
    // Basic push/pop, wrap-around, underflow and clear.
    add(1, 0, 8'h01, 0, 32'h1, 0, "rst_status");
    add(1, 0, 8'h02, 0, 32'h0, 0, "rst_count");
    add(1, 1, 8'h00, 32'h11111111, 32'h0, 0, "push1");
    add(1, 1, 8'h00, 32'h22222222, 32'h0, 0, "push2");
    add(1, 1, 8'h00, 32'h33333333, 32'h0, 0, "push3");
    add(1, 0, 8'h02, 0, 32'h3, 0, "count3");
    add(1, 0, 8'h00, 0, 32'h11111111, 0, "pop1");
    add(1, 0, 8'h00, 0, 32'h22222222, 0, "pop2");
    add(1, 0, 8'h00, 0, 32'h33333333, 0, "pop3");
    add(1, 0, 8'h01, 0, 32'h1, 0, "status_after_pops");
    add(0, 1, 8'h00, 32'hFFFFFFFF, 32'h1, 0, "unselected_write");
    add(1, 0, 8'h02, 0, 32'h0, 0, "count_unselected");
    for (int i = 0; i < 6; i++) add(1, 1, 8'h00, 32'hB0 + i, 32'h0, 0, "wrap_push6");
    for (int i = 0; i < 6; i++) add(1, 0, 8'h00, 0, 32'hB0 + i, 0, "wrap_pop6");
    for (int i = 0; i < 5; i++) add(1, 1, 8'h00, 32'hA0 + i, 32'hB5, 0, "wrap_push5");
    for (int i = 0; i < 5; i++) add(1, 0, 8'h00, 0, 32'hA0 + i, 0, "wrap_pop5");
    add(1, 0, 8'h02, 0, 32'h0, 0, "wrap_count");
    add(1, 0, 8'h00, 0, 32'h0, 0, "underflow_pop");
    add(1, 0, 8'h01, 0, 32'h9, 1, "underflow_status");
    add(1, 1, 8'h01, 32'h8, 32'h9, 1, "clear_udf");
    add(1, 0, 8'h01, 0, 32'h1, 0, "status_after_clr");
    add(1, 1, 8'h00, 32'hC0, 32'h1, 0, "pre_clear_push");
    add(1, 1, 8'h00, 32'hC1, 32'h1, 0, "pre_clear_push");
    add(1, 1, 8'h00, 32'hC2, 32'h1, 0, "pre_clear_push");
    add(1, 1, 8'h04, 32'h12345678, 32'h1, 0, "write_unmapped");
    add(1, 0, 8'h02, 0, 32'h3, 0, "count_before_clear");
    add(1, 1, 8'h03, 32'h0, 32'h3, 0, "clear");
    add(1, 0, 8'h02, 0, 32'h0, 0, "count_after_clear");
    add(1, 0, 8'h01, 0, 32'h1, 0, "status_after_clear");
    add(1, 0, 8'h03, 0, 32'h0, 0, "read_clear_reg");
    add(1, 0, 8'h05, 0, 32'h0, 0, "read_unmapped");

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_dout("reset_dout", 32'h0);
    chk_irq("reset_irq", 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].din);
      chk_dout(vecs[i].name, vecs[i].exp_dout);
      chk_irq(vecs[i].name, vecs[i].exp_irq);
    end

    // Overflow: fill to DEPTH, push one more, drain without the dropped word.
    for (int i = 0; i < 8; i++) apply(1, 1, 8'h00, 32'hD0 + i);
    apply(1, 1, 8'h00, 32'hDEADBEEF);
    chk_irq("ovf_irq_not_yet", 1'b0);
    apply(1, 0, 8'h02, 0);
    chk_dout("ovf_count", 32'h8);
    chk_irq("ovf_irq", 1'b1);
    apply(1, 0, 8'h01, 0);
    chk_dout("ovf_status", 32'h6);
    apply(1, 0, 8'h12, 0);
    chk_dout("alias_count", 32'h8);
    for (int i = 0; i < 8; i++) begin
      apply(1, 0, 8'h00, 0);
      chk_dout("ovf_drain", 32'hD0 + i);
    end
    apply(1, 0, 8'h01, 0);
    chk_dout("ovf_status_empty", 32'h5);
    apply(1, 1, 8'h01, 32'h4);
    apply(0, 0, 8'h00, 0);
    chk_irq("ovf_cleared_irq", 1'b0);
    apply(1, 0, 8'h01, 0);
    chk_dout("ovf_cleared_status", 32'h1);

    // Reset mid-activity clears pointers, flags, S_dout and irq.
    apply(1, 0, 8'h00, 0);
    apply(1, 1, 8'h00, 32'h5);
    apply(1, 0, 8'h01, 0);
    chk_dout("pre_reset_status", 32'h8);
    chk_irq("pre_reset_irq", 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk_dout("post_reset_dout", 32'h0);
    chk_irq("post_reset_irq", 1'b0);
    apply(1, 0, 8'h02, 0);
    chk_dout("post_reset_count", 32'h0);
    apply(1, 0, 8'h01, 0);
    chk_dout("post_reset_status", 32'h1);
    chk_irq("post_reset_irq2", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
